// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - RV32I field-to-word encoder with one output register stage and an error counter
module instruction_encoder #(
    parameter int ERROR_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   format,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   destination_reg,
    input  logic [4:0]                   source_reg_1,
    input  logic [4:0]                   source_reg_2,
    input  logic [2:0]                   subfunction_3,
    input  logic [6:0]                   subfunction_7,
    input  logic [31:0]                  immediate,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  instruction,
    output logic                         out_error,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } format_e;

    localparam logic [ERROR_COUNT_WIDTH-1:0] COUNT_MAX = {ERROR_COUNT_WIDTH{1'b1}};

    logic                         out_valid_q, out_valid_d;
    logic [31:0]                  instr_q, instr_d;
    logic                         err_q, err_d;
    logic [ERROR_COUNT_WIDTH-1:0] count_q, count_d;

    logic        accept;
    logic [31:0] enc_word;
    logic        enc_err;

    // Sign-extension checks: the bits above each format's immediate field must be copies of its sign bit.
    logic fits_12, fits_13, fits_21;
    assign fits_12 = (&immediate[31:11]) || ~(|immediate[31:11]);
    assign fits_13 = (&immediate[31:12]) || ~(|immediate[31:12]);
    assign fits_21 = (&immediate[31:20]) || ~(|immediate[31:20]);

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        case (format)
            FMT_R: begin
                enc_word = {subfunction_7, source_reg_2, source_reg_1, subfunction_3,
                            destination_reg, opcode};
            end
            FMT_I: begin
                enc_word = {immediate[11:0], source_reg_1, subfunction_3, destination_reg, opcode};
                enc_err  = !fits_12;
            end
            FMT_S: begin
                enc_word = {immediate[11:5], source_reg_2, source_reg_1, subfunction_3,
                            immediate[4:0], opcode};
                enc_err  = !fits_12;
            end
            FMT_B: begin
                enc_word = {immediate[12], immediate[10:5], source_reg_2, source_reg_1,
                            subfunction_3, immediate[4:1], immediate[11], opcode};
                enc_err  = !fits_13 || immediate[0];
            end
            FMT_U: begin
                enc_word = {immediate[31:12], destination_reg, opcode};
                enc_err  = |immediate[11:0];
            end
            FMT_J: begin
                enc_word = {immediate[20], immediate[10:1], immediate[11], immediate[19:12],
                            destination_reg, opcode};
                enc_err  = !fits_21 || immediate[0];
            end
            default: begin
                enc_word = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Word, flag and counter only move on accept; a bare drain just drops out_valid.
    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        count_d     = count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            instr_d     = enc_word;
            err_d       = enc_err;
            if (enc_err && (count_q != COUNT_MAX)) begin
                count_d = count_q + ERROR_COUNT_WIDTH'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            instr_q     <= 32'h0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign instruction = instr_q;
    assign out_error   = err_q;
    assign error_count = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - vector table, handshake sequences and randomized model check for instruction_encoder
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  format;
    logic [6:0]  opcode;
    logic [4:0]  destination_reg;
    logic [4:0]  source_reg_1;
    logic [4:0]  source_reg_2;
    logic [2:0]  subfunction_3;
    logic [6:0]  subfunction_7;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        out_error;
    logic [7:0]  error_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.ERROR_COUNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .format(format), .opcode(opcode), .destination_reg(destination_reg),
        .source_reg_1(source_reg_1), .source_reg_2(source_reg_2),
        .subfunction_3(subfunction_3), .subfunction_7(subfunction_7),
        .immediate(immediate), .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .out_error(out_error), .error_count(error_count)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        format = v.fmt; opcode = v.op; destination_reg = v.rd; source_reg_1 = v.rs1;
        source_reg_2 = v.rs2; subfunction_3 = v.f3; subfunction_7 = v.f7; immediate = v.imm;
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] w, input logic e);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.exp_word = w; v.exp_err = e;
        return v;
    endfunction

    // Reference: word assembled with shifts/masks, representability judged by signed numeric range.
    function automatic void ref_encode(input vec_t v, output logic [31:0] w, output logic e);
        longint s;
        logic [31:0] m;
        s = longint'($signed(v.imm));
        m = v.imm;
        w = 32'h0;
        e = 1'b0;
        case (v.fmt)
            3'd0: w = (32'(v.f7) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15) |
                      (32'(v.f3) << 12) | (32'(v.rd) << 7) | 32'(v.op);
            3'd1: begin
                w = ((m & 32'hFFF) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) |
                    (32'(v.rd) << 7) | 32'(v.op);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                w = (((m >> 5) & 32'h7F) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15) |
                    (32'(v.f3) << 12) | ((m & 32'h1F) << 7) | 32'(v.op);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd3: begin
                w = (((m >> 12) & 1) << 31) | (((m >> 5) & 32'h3F) << 25) | (32'(v.rs2) << 20) |
                    (32'(v.rs1) << 15) | (32'(v.f3) << 12) | (((m >> 1) & 32'hF) << 8) |
                    (((m >> 11) & 1) << 7) | 32'(v.op);
                e = !(s >= -4096 && s <= 4095 && (s % 2 == 0));
            end
            3'd4: begin
                w = (m & 32'hFFFFF000) | (32'(v.rd) << 7) | 32'(v.op);
                e = (m % 4096) != 0;
            end
            3'd5: begin
                w = (((m >> 20) & 1) << 31) | (((m >> 1) & 32'h3FF) << 21) |
                    (((m >> 11) & 1) << 20) | (((m >> 12) & 32'hFF) << 12) |
                    (32'(v.rd) << 7) | 32'(v.op);
                e = !(s >= -1048576 && s <= 1048575 && (s % 2 == 0));
            end
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 4))
            0: return $urandom();
            1: return 32'($signed($urandom_range(0, 8192)) - 4096);
            2: return 32'($signed($urandom_range(0, 4194304)) - 2097152);
            3: return $urandom() & 32'hFFFFF000;
            default: return 32'($signed($urandom_range(0, 16)) - 8);
        endcase
    endfunction

    vec_t v, a, b;
    logic [31:0] rw;
    logic        re;
    logic        m_valid;
    logic [31:0] m_word;
    logic        m_err;
    int          m_cnt;
    int          exp_cnt;
    logic        acc;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        vecs.push_back(mk(1, 7'h13, 1, 0, 0, 0, 0, 32'd5,        32'h00500093, 0));
        vecs.push_back(mk(0, 7'h33, 3, 1, 2, 0, 0, 32'h0,        32'h002081B3, 0));
        vecs.push_back(mk(2, 7'h23, 0, 1, 2, 2, 0, 32'd8,        32'h0020A423, 0));
        vecs.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFE000EE3, 0));
        vecs.push_back(mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 0));
        vecs.push_back(mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h00000800, 32'h001000EF, 0));
        vecs.push_back(mk(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048,     32'h80000093, 1));
        vecs.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd6,        32'h00000363, 0));
        vecs.push_back(mk(3, 7'h63, 0, 0, 0, 0, 0, 32'd3,        32'h00000163, 1));
        vecs.push_back(mk(7, 7'h13, 1, 0, 0, 0, 0, 32'd5,        32'h00000000, 1));
        vecs.push_back(mk(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFF800, 32'h80000093, 0));
        vecs.push_back(mk(4, 7'h37, 5, 0, 0, 0, 0, 32'h00000123, 32'h000002B7, 1));
        vecs.push_back(mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'hFFF00000, 32'h800000EF, 0));
        vecs.push_back(mk(0, 7'h33, 3, 1, 2, 0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 0));
        vecs.push_back(mk(2, 7'h23, 0, 0, 0, 0, 0, 32'hFFFFF7FF, 32'h7E000FA3, 1));

        tick(); tick();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_instruction", instruction, 0);
        chk("reset_out_error", 32'(out_error), 0);
        chk("reset_error_count", 32'(error_count), 0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 1);

        // Table: back-to-back, one word per cycle
        exp_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
            tick();
            if (vecs[i].exp_err) exp_cnt++;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_instruction", i), instruction, vecs[i].exp_word);
            chk($sformatf("vec%0d_out_error", i), 32'(out_error), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_error_count", i), 32'(error_count), 32'(exp_cnt));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_instruction_kept", instruction, vecs[vecs.size()-1].exp_word);

        // Backpressure: word A held while B waits, then accept+drain in one edge
        a = vecs[0]; b = vecs[1];
        out_ready = 1'b0; in_valid = 1'b1; drive(a);
        tick();
        drive(b);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready_low", 32'(in_ready), 0);
            tick();
            chk("bp_out_valid_held", 32'(out_valid), 1);
            chk("bp_instruction_held", instruction, a.exp_word);
            chk("bp_count_held", 32'(error_count), 32'(exp_cnt));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(in_ready), 1);
        tick();
        chk("bp_b_valid", 32'(out_valid), 1);
        chk("bp_b_word", instruction, b.exp_word);
        in_valid = 1'b0;
        tick();
        chk("bp_no_dup", 32'(out_valid), 0);

        // Saturation
        reset = 1'b1; tick(); reset = 1'b0;
        drive(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == 254) chk("sat_reach_255", 32'(error_count), 255);
        end
        chk("sat_hold_255", 32'(error_count), 255);
        chk("sat_word_zero", instruction, 0);

        // Reset while output is stalled
        out_ready = 1'b0;
        drive(vecs[3]);
        tick();
        chk("rst_mid_valid_before", 32'(out_valid), 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_error_count", 32'(error_count), 0);
        chk("rst_mid_instruction", instruction, 0);
        reset = 1'b0;
        drive(vecs[0]);
        tick();
        chk("rst_first_word", instruction, 32'h00500093);
        chk("rst_first_valid", 32'(out_valid), 1);

        // Randomized run against the reference model
        reset = 1'b1; in_valid = 1'b0; tick(); reset = 1'b0;
        m_valid = 1'b0; m_word = 0; m_err = 1'b0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            v = mk(3'($urandom_range(0, 7)), 7'($urandom()), 5'($urandom()), 5'($urandom()),
                   5'($urandom()), 3'($urandom()), 7'($urandom()), rand_imm(), 0, 0);
            drive(v);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            acc = in_valid && (!m_valid || out_ready);
            ref_encode(v, rw, re);
            tick();
            if (acc) begin
                m_valid = 1'b1; m_word = rw; m_err = re;
                if (re && m_cnt < 255) m_cnt++;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd_instruction", instruction, m_word);
            chk("rnd_out_error", 32'(out_error), 32'(m_err));
            chk("rnd_error_count", 32'(error_count), 32'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Encodes decoded RISC-V RV32I instruction fields back into a 32-bit instruction word. It performs the inverse of the field and immediate decode used in the front end. Used by the self-test sequencer and the debug injection path to build instruction words for the fetch and decode path. Has a valid/ready input, a single registered output stage with backpressure, and an immediate-range checker with a saturating error counter.

Parameters:
ERROR_COUNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept input this cycle
format  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
opcode  input  7  placed in instruction[6:0]
destination_reg  input  5  rd
source_reg_1  input  5  rs1
source_reg_2  input  5  rs2
subfunction_3  input  3  funct3
subfunction_7  input  7  funct7 (R only)
immediate  input  32  full sign-extended immediate value
out_valid  output  1  instruction/out_error valid
out_ready  input  1  consumer accepts output
instruction  output  32  encoded word
out_error  output  1  immediate not representable, or illegal format
error_count  output  ERROR_COUNT_WIDTH  saturating count of accepted erroneous inputs

Behaviour:
- Reset (synchronous, high): out_valid=0, instruction=0, out_error=0, error_count=0. Reset overrides any simultaneous handshake; a pending output is dropped.
- in_ready = !out_valid || out_ready (combinational). Input is accepted when in_valid && in_ready.
- Latency is 1 cycle. On accept, instruction, out_error and out_valid=1 are registered at the next edge.
- Output holds stable while out_valid && !out_ready.
- If out_ready is high and there is no new accept, out_valid clears to 0; instruction and out_error keep their last values.
- Back-to-back accept plus drain in the same cycle is allowed, giving full throughput of 1 word per cycle.
- Encoding (imm = immediate):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Fields unused by a format are ignored.
- Error rules:
  - I and S: error unless imm[31:11] are all equal.
  - B: error unless imm[31:12] are all equal and imm[0]=0.
  - J: error unless imm[31:20] are all equal and imm[0]=0.
  - U: error unless imm[11:0]=0.
  - R: never an error.
  - Format 6 or 7: error, and instruction=32'h0.
  - On an immediate error the word is still encoded from the truncated bits as above.
- error_count increments by 1 on each accepted input whose out_error is 1, registered with the output. It saturates at all-ones and has no wrap.
- Encoding, error and counter logic act only on accept. Input changes without acceptance have no effect.

Test Plan:
- addi x1,x0,5: format=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=5 -> next cycle out_valid=1, instruction=0x00500093, out_error=0.
- Mixed formats, back-to-back, out_ready=1:
  - add x3,x1,x2 (R, op 0x33) -> 0x002081B3
  - sw x2,8(x1) (S, op 0x23, f3=2) -> 0x0020A423
  - beq x0,x0,-4 (B, op 0x63, imm=0xFFFFFFFC) -> 0xFE000EE3
  - lui x5,0x12345000 (U, op 0x37) -> 0x123452B7
  - jal x1,2048 (J, op 0x6F) -> 0x001000EF
  - Required: one word per cycle, in order.
- Errors:
  - I with imm=2048 -> out_error=1, error_count=1.
  - B with imm=6 -> no error.
  - B with imm=3 -> error, error_count=2.
  - format=7 -> instruction=0, error, error_count=3.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instruction stable, no extra accepts. Raise out_ready -> accept and drain in the same cycle, with no loss or duplication.
- Saturation: 300 erroneous accepts with ERROR_COUNT_WIDTH=8 -> error_count=255 and holds.
- Reset mid-operation: assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and error_count=0. First accept after reset encodes correctly.
